// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {Bout, D} = A - B - Bin, one bit per clock, LSB first,
// through a single full-subtractor cell behind a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;
    logic               v_q, v_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               a_i, b_i, d_i, br_nxt, last_bit;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        bout_d   = bout_q;
        v_d      = v_q;

        a_i      = a_q[0];
        b_i      = b_q[0];
        d_i      = a_i ^ b_i ^ br_q;
        br_nxt   = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Operands shift right so bit i is always at position 0.
                d_d   = {d_i, d_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // At the MSB step a_i/b_i are the latched sign bits and d_i is D[MSB].
                    bout_d  = br_nxt;
                    v_d     = (a_i != b_i) && (d_i != a_i);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;
    assign V    = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboard of expected results,
// handshake timing, start-while-busy, mid-run reset and an exhaustive sweep.
module tb_serial_subtractor;

    localparam int unsigned W = 4;
    localparam int unsigned CW = $clog2(W) + 1;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic         Bin;
    logic         busy, done, Bout, V;
    logic [W-1:0] D;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    serial_subtractor #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
        .busy(busy), .done(done), .D(D), .Bout(Bout), .V(V)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain unsigned subtraction and signed range check
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] diff;
        int         s;
        diff = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        model.d    = diff[W-1:0];
        model.bout = diff[W];
        model.v    = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    endfunction

    // Wait (bounded) for DUT idle
    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || done) && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            errors++;
            $display("FAIL %s idle_timeout busy=%b done=%b", name, busy, done);
        end
    endtask

    // One operation: start, measure busy length, pop scoreboard at done
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input string name, input bit chk_timing);
        int   nbusy = 0;
        int   n = 0;
        exp_t e;
        logic [W:0] sum;
        wait_idle(name);
        A = a; B = b; Bin = bin; start = 1'b1;
        exp_q.push_back(model(a, b, bin));
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
        while (!done && n < 3 * W) begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s done_timeout got=none want=done", name);
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if ({D, Bout, V} !== {e.d, e.bout, e.v}) begin
            errors++;
            $display("FAIL %s result got D=%h Bout=%b V=%b want D=%h Bout=%b V=%b",
                     name, D, Bout, V, e.d, e.bout, e.v);
        end
        sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~bin};
        checks++;
        if ({~Bout, D} !== sum) begin
            errors++;
            $display("FAIL %s identity got=%h want=%h", name, {~Bout, D}, sum);
        end
        if (chk_timing) begin
            checks++;
            if (nbusy != W) begin
                errors++;
                $display("FAIL %s busy_cycles got=%0d want=%0d", name, nbusy, W);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || {D, Bout, V} !== {e.d, e.bout, e.v}) begin
                errors++;
                $display("FAIL %s done_pulse_hold got done=%b D=%h want done=0 D=%h",
                         name, done, D, e.d);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, D, Bout, V} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b D=%h Bout=%b V=%b want all 0",
                     busy, done, D, Bout, V);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(4'd9, 4'd3, 1'b0, "9-3", 1'b1);
        run_op(4'd3, 4'd9, 1'b0, "3-9", 1'b1);
        run_op(4'd0, 4'd0, 1'b1, "0-0-1", 1'b1);
        run_op(4'h8, 4'h1, 1'b0, "8-1_ovf", 1'b1);
        run_op(4'h7, 4'hF, 1'b0, "7-F_ovf", 1'b1);
        run_op(4'h8, 4'h0, 1'b1, "8-0-1_ovf", 1'b1);
    endtask

    // start held high; operands changed right after each capture
    task automatic test_back_to_back();
        logic [W-1:0] as[3] = '{4'h5, 4'hC, 4'h2};
        logic [W-1:0] bs[3] = '{4'h6, 4'h3, 4'h2};
        logic         bi[3] = '{1'b0, 1'b1, 1'b1};
        int   last_done = 0;
        int   n;
        exp_t e;
        wait_idle("b2b");
        A = as[0]; B = bs[0]; Bin = bi[0]; start = 1'b1;
        exp_q.push_back(model(as[0], bs[0], bi[0]));
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!busy && n < 4 * W) begin @(negedge clk); n++; end
            if (i < 2) begin
                A = as[i+1]; B = bs[i+1]; Bin = bi[i+1];
                exp_q.push_back(model(as[i+1], bs[i+1], bi[i+1]));
            end else begin
                start = 1'b0;
                A = 4'hF; B = 4'hF; Bin = 1'b1;
            end
            n = 0;
            while (!done && n < 4 * W) begin @(negedge clk); n++; end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL b2b_done_timeout op=%0d got=none want=done", i);
                void'(exp_q.pop_front());
                continue;
            end
            e = exp_q.pop_front();
            checks++;
            if ({D, Bout, V} !== {e.d, e.bout, e.v}) begin
                errors++;
                $display("FAIL b2b_result op=%0d got D=%h Bout=%b V=%b want D=%h Bout=%b V=%b",
                         i, D, Bout, V, e.d, e.bout, e.v);
            end
            if (i > 0) begin
                checks++;
                if (cyc - last_done != W + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing op=%0d got=%0d want=%0d", i, cyc - last_done, W + 2);
                end
            end
            last_done = cyc;
            @(negedge clk);
        end
        n = 0;
        repeat (2 * W + 4) begin
            if (done || busy) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL b2b_extra_activity got=%0d want=0", n);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone = 0;
        wait_idle("rst_mid");
        A = 4'hE; B = 4'h3; Bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, D, Bout, V} !== '0) begin
            errors++;
            $display("FAIL rst_mid_state got busy=%b done=%b D=%h Bout=%b V=%b want all 0",
                     busy, done, D, Bout, V);
        end
        rst = 1'b0;
        repeat (W + 4) begin
            if (done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_done got dones=%0d busy=%b want 0 0", ndone, busy);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 512; i++) begin
            run_op(W'(i >> 5), W'(i >> 1), 1'(i), "sweep", 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
